// File: rtl/hac_flop_pkg.sv
// Shared defaults and helpers for the hac positive-edge flop pipeline.
package hac_flop_pkg;

  localparam int unsigned DEPTH_DEF   = 4;
  localparam int unsigned CNT_W_DEF   = 8;
  localparam logic        RST_VAL_DEF = 1'b0;

  // Increment v, holding at the all-ones value of a w-bit counter (w <= 32).
  function automatic logic [31:0] sat_inc(input logic [31:0] v,
                                          input int unsigned w);
    logic [31:0] max_v;
    max_v = (32'(1) << w) - 32'(1);
    if (w >= 32) begin
      max_v = '1;
    end
    return (v >= max_v) ? max_v : v + 32'(1);
  endfunction

endpackage : hac_flop_pkg

// File: rtl/hac_dff_cell.sv
// Single positive-edge D flop with synchronous reset and hold enable.
module hac_dff_cell
  import hac_flop_pkg::*;
#(
  parameter logic RST_VAL = RST_VAL_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic d,
  output logic q
);

  // Reset wins over enable; with en low the stage holds its value.
  always_ff @(posedge clk) begin
    if (rst) begin
      q <= RST_VAL;
    end else if (en) begin
      q <= d;
    end
  end

endmodule : hac_dff_cell

// File: rtl/hac_pos_flop.sv
// DEPTH-stage serial flop pipeline with per-stage taps and a saturating
// counter of z value changes.
module hac_pos_flop
  import hac_flop_pkg::*;
#(
  parameter int unsigned DEPTH   = DEPTH_DEF,
  parameter logic        RST_VAL = RST_VAL_DEF,
  parameter int unsigned CNT_W   = CNT_W_DEF,
  parameter string       NAME    = "F"
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             a,
  output logic             z,
  output logic [DEPTH-1:0] taps,
  output logic [CNT_W-1:0] z_toggles
);

  logic [DEPTH-1:0] stage_q;
  logic             z_nxt_c;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Reject degenerate parameterisations at elaboration, labelled by NAME.
  if (DEPTH < 1) begin : g_bad_depth
    $error("%s: DEPTH must be >= 1", NAME);
  end
  if ((CNT_W < 1) || (CNT_W > 32)) begin : g_bad_cnt_w
    $error("%s: CNT_W must be in 1..32", NAME);
  end

  // Stage chain; block label f keeps hierarchical names f[i].u_dff stable.
  for (genvar i = 0; i < DEPTH; i++) begin : f
    logic d_c;
    if (i == 0) begin : g_head
      assign d_c = a;
    end else begin : g_body
      assign d_c = stage_q[i-1];
    end
    hac_dff_cell #(
      .RST_VAL (RST_VAL)
    ) u_dff (
      .clk (clk),
      .rst (rst),
      .en  (en),
      .d   (d_c),
      .q   (stage_q[i])
    );
  end

  // Value the last stage will take at the coming edge when shifting.
  if (DEPTH == 1) begin : g_znxt_single
    assign z_nxt_c = a;
  end else begin : g_znxt_chain
    assign z_nxt_c = stage_q[DEPTH-2];
  end

  // Next count: bump (saturating) only when a shift changes z.
  always_comb begin
    cnt_d = cnt_q;
    if (en && (z_nxt_c != stage_q[DEPTH-1])) begin
      cnt_d = CNT_W'(sat_inc(32'(cnt_q), CNT_W));
    end
  end

  // Toggle counter register, cleared only by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign z         = stage_q[DEPTH-1];
  assign taps      = stage_q;
  assign z_toggles = cnt_q;

endmodule : hac_pos_flop

// File: tb/tb_hac_pos_flop.sv
// Directed bench for hac_pos_flop: reset, latency, hold, mid-stream reset,
// counter saturation and the single-stage case.

// Bench-only clock source: low at t=0, first rise at HALF_PERIOD.
module clk_gen #(
  parameter int unsigned HALF_PERIOD = 50
) (
  output logic clk
);
  initial begin
    clk = 1'b0;
    forever #(HALF_PERIOD) clk = ~clk;
  end
endmodule : clk_gen

module tb_hac_pos_flop;

  logic       clk;
  logic       rst;
  logic       en;
  logic       a;

  logic       z;
  logic [3:0] taps;
  logic [7:0] z_toggles;

  logic       z_s;
  logic [3:0] taps_s;
  logic [1:0] z_toggles_s;

  logic       z_1;
  logic [0:0] taps_1;
  logic [7:0] z_toggles_1;

  int tests = 0;
  int fails = 0;

  clk_gen #(.HALF_PERIOD(50)) u_clk (.clk(clk));

  // Main configuration: DEPTH=4, CNT_W=8.
  hac_pos_flop #(.DEPTH(4), .RST_VAL(1'b0), .CNT_W(8), .NAME("MAIN")) u_dut (
    .clk(clk), .rst(rst), .en(en), .a(a),
    .z(z), .taps(taps), .z_toggles(z_toggles)
  );

  // Narrow counter for saturation: DEPTH=4, CNT_W=2.
  hac_pos_flop #(.DEPTH(4), .RST_VAL(1'b0), .CNT_W(2), .NAME("SAT")) u_sat (
    .clk(clk), .rst(rst), .en(en), .a(a),
    .z(z_s), .taps(taps_s), .z_toggles(z_toggles_s)
  );

  // Single-stage configuration.
  hac_pos_flop #(.DEPTH(1), .RST_VAL(1'b0), .CNT_W(8), .NAME("D1")) u_d1 (
    .clk(clk), .rst(rst), .en(en), .a(a),
    .z(z_1), .taps(taps_1), .z_toggles(z_toggles_1)
  );

  task automatic check(input string tag, input logic [7:0] obs,
                       input logic [7:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic at(input longint t);
    if ($time < t) #(t - $time);
  endtask

  initial begin
    // Reset across the edge at 50 with a=1.
    rst = 1'b1;
    en  = 1'b1;
    a   = 1'b1;

    at(60);
    rst = 1'b0;
    a   = 1'b0;
    check("rst_z",       8'(z),           8'd0);
    check("rst_taps",    8'(taps),        8'h0);
    check("rst_tog",     z_toggles,       8'd0);
    check("rst_sat_tog", 8'(z_toggles_s), 8'd0);
    check("rst_d1_z",    8'(z_1),         8'd0);

    // Latency: a edges at 420/820/920/1020/1120/1420.
    at(420);  a = 1'b1;
    at(440);  check("d1_before", 8'(z_1),    8'd0);
    at(470);  check("d1_after",  8'(z_1),    8'd1);
              check("d1_taps",   8'(taps_1), 8'd1);
    at(740);  check("lat_pre750",  8'(z), 8'd0);
    at(770);  check("lat_rise750", 8'(z), 8'd1);
    at(820);  a = 1'b0;
    at(920);  a = 1'b1;
    at(1020); a = 1'b0;
    at(1120); a = 1'b1;
    at(1140); check("lat_pre1150",  8'(z),    8'd1);
    at(1170); check("lat_fall1150", 8'(z),    8'd0);
              check("lat_taps1170", 8'(taps), 8'h5);
    at(1270); check("lat_rise1250", 8'(z), 8'd1);
    at(1370); check("lat_fall1350", 8'(z), 8'd0);
    at(1420); a = 1'b0;
    at(1470); check("lat_rise1450", 8'(z),           8'd1);
              check("lat_tog1470",  z_toggles,       8'd5);
              check("sat_tog1470",  8'(z_toggles_s), 8'd3);

    // Hold: freeze for edges 1650/1750/1850 while a toggles.
    at(1480); a = 1'b1;
    at(1560); check("hold_taps_in", 8'(taps), 8'hD);
              en = 1'b0;
    at(1600); a = 1'b0;
    at(1700); a = 1'b1;
    at(1800); a = 1'b0;
    at(1860); check("hold_taps_frz", 8'(taps),  8'hD);
              check("hold_tog_frz",  z_toggles, 8'd5);
              en = 1'b1;
    at(1960); check("resume_taps", 8'(taps),  8'hA);
              check("resume_z",    8'(z),     8'd1);
              check("resume_tog",  z_toggles, 8'd5);

    // Mid-stream reset with en=0 at edge 2050.
              rst = 1'b1;
              en  = 1'b0;
    at(2060); check("mrst_taps",    8'(taps),        8'h0);
              check("mrst_z",       8'(z),           8'd0);
              check("mrst_tog",     z_toggles,       8'd0);
              check("mrst_sat_tog", 8'(z_toggles_s), 8'd0);
              rst = 1'b0;
              en  = 1'b1;
              a   = 1'b1;

    // Saturation: a alternates every edge; z starts toggling at edge 4.
    for (int k = 1; k <= 12; k++) begin
      @(posedge clk);
      #10;
      if (k == 3) begin
        check("sat_k3_main", z_toggles,       8'd0);
        check("sat_k3_sat",  8'(z_toggles_s), 8'd0);
      end
      if (k == 4) begin
        check("sat_k4_z",    8'(z),           8'd1);
        check("sat_k4_main", z_toggles,       8'd1);
      end
      if (k == 6) begin
        check("sat_k6_sat",  8'(z_toggles_s), 8'd3);
      end
      if (k == 7) begin
        check("sat_k7_main", z_toggles,       8'd4);
        check("sat_k7_sat",  8'(z_toggles_s), 8'd3);
      end
      if (k == 12) begin
        check("sat_k12_main", z_toggles,       8'd9);
        check("sat_k12_sat",  8'(z_toggles_s), 8'd3);
        check("d1_k12_tog",   z_toggles_1,     8'd12);
      end
      a = ~a;
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule : tb_hac_pos_flop
